ddr3_avl_arbiter: RTL and testbench
===================================

DDR3_AVL_ARBITER -- requirements
Module: ddr3_avl_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 26, DDR3 Avalon word-address width.
REQ-002 SHALL have parameter DATA_W, default 128, beat width.
REQ-003 SHALL have parameter TAG_DEPTH, default 8, max outstanding read bursts (power of 2).
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports pN_read_req / pN_write_req  in  1  command request; N=0 video fetch, N=1 host/CSR.
REQ-007 SHALL have port pN_addr  in  ADDR_W  burst start address.
REQ-008 SHALL have port pN_size  in  3  burst length in beats, 1..7.
REQ-009 SHALL have port pN_wr_data  in  DATA_W  current write beat.
REQ-010 SHALL have port pN_ready  out  1  read command or write beat accepted this cycle.
REQ-011 SHALL have ports pN_read_data_valid  out  1 and pN_read_data  out  DATA_W  returned read beat.
REQ-012 SHALL have ports ddr3_avl_ready in 1, ddr3_avl_burstbegin out 1, ddr3_avl_addr out ADDR_W, ddr3_avl_size out 3, ddr3_avl_wr_data out DATA_W, ddr3_avl_read_req out 1, ddr3_avl_write_req out 1, ddr3_avl_read_data_valid in 1, ddr3_avl_read_data in DATA_W.
REQ-013 SHALL have port err_orphan  out  1  sticky: read beat arrived with no outstanding tag.

Function
REQ-014 SHALL implement FSM states IDLE, RD_CMD, WR_BURST.
REQ-015 IDLE: arbitrate; latch winner port, addr, size; go RD_CMD (read) or WR_BURST (write); read_req wins over write_req within one port.
REQ-016 Read request SHALL be ineligible while tag FIFO full; other port remains eligible.
REQ-017 Latency: request sampled in IDLE at cycle T -> ddr3_avl_read_req/write_req high at T+1.
REQ-018 ddr3_avl_burstbegin SHALL be high only on first cycle of RD_CMD/WR_BURST, also when ddr3_avl_ready low.
REQ-019 ddr3_avl_addr/size SHALL be registered and held stable until command/last beat accepted; pN_size=0 latched as 1.
REQ-020 RD_CMD: read_req held until ddr3_avl_ready=1; that cycle push tag {port,size}, pulse granted pN_ready, return IDLE.
REQ-021 WR_BURST: write_req high; ddr3_avl_wr_data = granted pN_wr_data (combinational); each cycle with ddr3_avl_ready=1 pulse granted pN_ready and count beat; after size beats return IDLE.
REQ-022 Minimum one IDLE cycle between consecutive commands.
REQ-023 Read return: each ddr3_avl_read_data_valid routed combinationally to pN_read_data_valid of FIFO-head port; ddr3_avl_read_data broadcast to both pN_read_data.
REQ-024 Beat counter per head tag; pop when count reaches tag size; push and pop in same cycle SHALL keep count unchanged.
REQ-025 read_data_valid with FIFO empty: no pN valid, set err_orphan (cleared only by reset).
REQ-026 Requester SHALL hold request, addr, size stable until its pN_ready; withdrawal before grant has no effect.

Reset
REQ-027 reset_n low SHALL immediately force IDLE, all outputs 0, FIFO empty, counters 0, err_orphan 0, RR pointer to p0.
REQ-028 Reset mid-burst SHALL abandon command and discard outstanding tags.

Configuration
REQ-029 DDR3_ARB_RR_EN defined: round-robin, last-granted port loses priority at next arbitration; undefined: fixed priority, p0 always wins.

Verification
REQ-030 p0 read addr 0x10 size 4 -> read_req+burstbegin one cycle later; 4 read beats appear only on p0_read_data_valid.
REQ-031 p1 write size 3, ddr3_avl_ready toggling 1,0,1,1 -> exactly 3 p1_ready pulses, wr_data = p1 beats in order, burstbegin once.
REQ-032 p0 and p1 read same cycle, repeated -> without macro p0 always first; with DDR3_ARB_RR_EN grants alternate p0,p1,p0.
REQ-033 9 p1 reads size 1 with no return data -> 8 accepted, 9th stalled until one beat returns, then accepted.
REQ-034 ddr3_avl_read_data_valid with no outstanding read -> err_orphan=1 next cycle, no pN valid; reset_n low mid-write -> all outputs 0 immediately.

Source files
------------

// File: rtl/ddr3_avl_arbiter.sv
// Two-port Avalon arbiter in front of a DDR3 controller: video fetch (p0) and host/CSR (p1).
// Optional macro DDR3_ARB_RR_EN selects round-robin arbitration; otherwise p0 has fixed priority.
module ddr3_avl_arbiter #(
  parameter int ADDR_W    = 26,
  parameter int DATA_W    = 128,
  parameter int TAG_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p0_read_req,
  input  logic              p0_write_req,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [2:0]        p0_size,
  input  logic [DATA_W-1:0] p0_wr_data,
  output logic              p0_ready,
  output logic              p0_read_data_valid,
  output logic [DATA_W-1:0] p0_read_data,
  input  logic              p1_read_req,
  input  logic              p1_write_req,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [2:0]        p1_size,
  input  logic [DATA_W-1:0] p1_wr_data,
  output logic              p1_ready,
  output logic              p1_read_data_valid,
  output logic [DATA_W-1:0] p1_read_data,
  input  logic              ddr3_avl_ready,
  output logic              ddr3_avl_burstbegin,
  output logic [ADDR_W-1:0] ddr3_avl_addr,
  output logic [2:0]        ddr3_avl_size,
  output logic [DATA_W-1:0] ddr3_avl_wr_data,
  output logic              ddr3_avl_read_req,
  output logic              ddr3_avl_write_req,
  input  logic              ddr3_avl_read_data_valid,
  input  logic [DATA_W-1:0] ddr3_avl_read_data,
  output logic              err_orphan
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, RD_CMD, WR_BURST} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_port;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_size;
  logic [2:0]        r_beat;
  logic              r_first;
  logic              r_err;

  // Tag FIFO entry: {port, burst size}; one entry per outstanding read burst
  logic [3:0]        r_tag_mem [TAG_DEPTH];
  logic [PW:0]       r_wr_ptr, r_rd_ptr;
  logic [2:0]        r_rd_beat;

  logic              w_empty, w_full;
  logic [3:0]        w_head;
  logic              w_head_port;
  logic [2:0]        w_head_size;
  logic              w_rd_vld, w_push, w_pop;

  logic [1:0]        w_rd_ok, w_elig;
  logic              w_pri, w_win, w_grant;
  logic [ADDR_W-1:0] w_addr_sel;
  logic [2:0]        w_size_sel;
  logic              w_acc;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                       (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_head      = r_tag_mem[r_rd_ptr[PW-1:0]];
  assign w_head_port = w_head[3];
  assign w_head_size = w_head[2:0];
  assign w_rd_vld    = ddr3_avl_read_data_valid & ~w_empty;
  assign w_pop       = w_rd_vld && (r_rd_beat == w_head_size - 3'd1);
  assign w_push      = (r_state == RD_CMD) && ddr3_avl_ready;

  // A full tag FIFO blocks only reads; writes stay eligible
  assign w_rd_ok = {p1_read_req, p0_read_req} & {2{~w_full}};
  assign w_elig  = w_rd_ok | {p1_write_req, p0_write_req};

`ifdef DDR3_ARB_RR_EN
  logic r_rr_pri;
  assign w_pri = r_rr_pri;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_rr_pri <= 1'b0;
    else if (w_grant) r_rr_pri <= ~w_win;
  end
`else
  assign w_pri = 1'b0;
`endif

  assign w_win      = w_elig[w_pri] ? w_pri : ~w_pri;
  assign w_addr_sel = w_win ? p1_addr : p0_addr;
  assign w_size_sel = w_win ? p1_size : p0_size;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_elig) begin
          w_grant     = 1'b1;
          w_state_nxt = w_rd_ok[w_win] ? RD_CMD : WR_BURST;
        end
      end
      RD_CMD:   if (ddr3_avl_ready) w_state_nxt = IDLE;
      WR_BURST: if (ddr3_avl_ready && (r_beat == r_size - 3'd1)) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_port  <= 1'b0;
      r_addr  <= '0;
      r_size  <= '0;
      r_beat  <= '0;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_first <= w_grant;
      if (w_grant) begin
        r_port <= w_win;
        r_addr <= w_addr_sel;
        r_size <= (w_size_sel == 3'd0) ? 3'd1 : w_size_sel;
        r_beat <= '0;
      end else if ((r_state == WR_BURST) && ddr3_avl_ready) begin
        r_beat <= r_beat + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_tag_mem[r_wr_ptr[PW-1:0]] <= {r_port, r_size};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rd_beat <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_rd_vld) r_rd_beat <= w_pop ? 3'd0 : r_rd_beat + 3'd1;
      if (ddr3_avl_read_data_valid && w_empty) r_err <= 1'b1;
    end
  end

  assign w_acc = (r_state != IDLE) && ddr3_avl_ready;

  assign p0_ready            = w_acc & ~r_port;
  assign p1_ready            = w_acc &  r_port;
  assign p0_read_data_valid  = w_rd_vld & ~w_head_port;
  assign p1_read_data_valid  = w_rd_vld &  w_head_port;
  // Read data is a broadcast, but held at zero while reset is asserted
  assign p0_read_data        = reset_n ? ddr3_avl_read_data : '0;
  assign p1_read_data        = reset_n ? ddr3_avl_read_data : '0;

  assign ddr3_avl_burstbegin = r_first;
  assign ddr3_avl_addr       = r_addr;
  assign ddr3_avl_size       = r_size;
  assign ddr3_avl_read_req   = (r_state == RD_CMD);
  assign ddr3_avl_write_req  = (r_state == WR_BURST);
  assign ddr3_avl_wr_data    = (r_state != WR_BURST) ? '0 : (r_port ? p1_wr_data : p0_wr_data);
  assign err_orphan          = r_err;

endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// Directed bench for ddr3_avl_arbiter; expectations follow DDR3_ARB_RR_EN when defined.
module tb_ddr3_avl_arbiter;
  localparam int ADDR_W = 26;
  localparam int DATA_W = 128;

  logic clk, reset_n;
  logic p0_read_req, p0_write_req, p1_read_req, p1_write_req;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [2:0] p0_size, p1_size;
  logic [DATA_W-1:0] p0_wr_data, p1_wr_data;
  logic p0_ready, p1_ready, p0_read_data_valid, p1_read_data_valid;
  logic [DATA_W-1:0] p0_read_data, p1_read_data;
  logic ddr3_avl_ready, ddr3_avl_burstbegin, ddr3_avl_read_req, ddr3_avl_write_req;
  logic [ADDR_W-1:0] ddr3_avl_addr;
  logic [2:0] ddr3_avl_size;
  logic [DATA_W-1:0] ddr3_avl_wr_data, ddr3_avl_read_data;
  logic ddr3_avl_read_data_valid, err_orphan;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] exp_seq;

  ddr3_avl_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_read_req(p0_read_req), .p0_write_req(p0_write_req), .p0_addr(p0_addr),
    .p0_size(p0_size), .p0_wr_data(p0_wr_data), .p0_ready(p0_ready),
    .p0_read_data_valid(p0_read_data_valid), .p0_read_data(p0_read_data),
    .p1_read_req(p1_read_req), .p1_write_req(p1_write_req), .p1_addr(p1_addr),
    .p1_size(p1_size), .p1_wr_data(p1_wr_data), .p1_ready(p1_ready),
    .p1_read_data_valid(p1_read_data_valid), .p1_read_data(p1_read_data),
    .ddr3_avl_ready(ddr3_avl_ready), .ddr3_avl_burstbegin(ddr3_avl_burstbegin),
    .ddr3_avl_addr(ddr3_avl_addr), .ddr3_avl_size(ddr3_avl_size),
    .ddr3_avl_wr_data(ddr3_avl_wr_data), .ddr3_avl_read_req(ddr3_avl_read_req),
    .ddr3_avl_write_req(ddr3_avl_write_req),
    .ddr3_avl_read_data_valid(ddr3_avl_read_data_valid),
    .ddr3_avl_read_data(ddr3_avl_read_data), .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef DDR3_ARB_RR_EN
    exp_seq = 3'b010;
`else
    exp_seq = 3'b000;
`endif
    reset_n = 1'b0;
    p0_read_req = 0; p0_write_req = 0; p0_addr = '0; p0_size = '0; p0_wr_data = '0;
    p1_read_req = 0; p1_write_req = 0; p1_addr = '0; p1_size = '0; p1_wr_data = '0;
    ddr3_avl_ready = 0; ddr3_avl_read_data_valid = 0; ddr3_avl_read_data = 128'hDEAD;
    #2;
    chk("rst_read_req", ddr3_avl_read_req, 0);
    chk("rst_write_req", ddr3_avl_write_req, 0);
    chk("rst_rdata", p0_read_data, 0);
    chk("rst_err", err_orphan, 0);
    #10;
    @(negedge clk) reset_n = 1'b1;
    step();

    // p0 read, addr 0x10, size 4
    p0_read_req = 1; p0_addr = 26'h10; p0_size = 3'd4; ddr3_avl_ready = 1;
    #1 chk("t1_idle_no_req", ddr3_avl_read_req, 0);
    step();
    chk("t1_read_req", ddr3_avl_read_req, 1);
    chk("t1_burstbegin", ddr3_avl_burstbegin, 1);
    chk("t1_addr", ddr3_avl_addr, 26'h10);
    chk("t1_size", ddr3_avl_size, 4);
    chk("t1_p0_ready", p0_ready, 1);
    chk("t1_p1_ready", p1_ready, 0);
    p0_read_req = 0;
    step();
    chk("t1_back_idle", ddr3_avl_read_req, 0);
    chk("t1_bb_low", ddr3_avl_burstbegin, 0);
    for (int k = 0; k < 4; k++) begin
      ddr3_avl_read_data_valid = 1; ddr3_avl_read_data = 128'hA0 + 128'(k);
      #1;
      chk("t1_p0_valid", p0_read_data_valid, 1);
      chk("t1_p1_valid", p1_read_data_valid, 0);
      chk("t1_p0_data", p0_read_data, 128'hA0 + 128'(k));
      step();
    end
    ddr3_avl_read_data_valid = 0;

    // p1 write size 3, ready pattern 1,0,1,1
    p1_write_req = 1; p1_addr = 26'h20; p1_size = 3'd3; p1_wr_data = 128'hB0; ddr3_avl_ready = 1;
    step();
    chk("t2_write_req", ddr3_avl_write_req, 1);
    chk("t2_bb", ddr3_avl_burstbegin, 1);
    chk("t2_rdy0", p1_ready, 1);
    chk("t2_p0_rdy", p0_ready, 0);
    chk("t2_wd0", ddr3_avl_wr_data, 128'hB0);
    chk("t2_size", ddr3_avl_size, 3);
    chk("t2_addr", ddr3_avl_addr, 26'h20);
    step();
    p1_wr_data = 128'hB1; ddr3_avl_ready = 0;
    #1;
    chk("t2_stall_rdy", p1_ready, 0);
    chk("t2_stall_bb", ddr3_avl_burstbegin, 0);
    chk("t2_stall_wr", ddr3_avl_write_req, 1);
    chk("t2_wd1_hold", ddr3_avl_wr_data, 128'hB1);
    step();
    ddr3_avl_ready = 1;
    #1;
    chk("t2_rdy1", p1_ready, 1);
    chk("t2_wd1", ddr3_avl_wr_data, 128'hB1);
    step();
    p1_wr_data = 128'hB2;
    #1;
    chk("t2_rdy2", p1_ready, 1);
    chk("t2_wd2", ddr3_avl_wr_data, 128'hB2);
    p1_write_req = 0;
    step();
    chk("t2_done_wr", ddr3_avl_write_req, 0);
    chk("t2_done_rdy", p1_ready, 0);
    chk("t2_done_wd", ddr3_avl_wr_data, 0);

    // Simultaneous reads from both ports, three rounds
    p0_read_req = 1; p0_addr = 26'h100; p0_size = 3'd1;
    p1_read_req = 1; p1_addr = 26'h200; p1_size = 3'd1;
    for (int r = 0; r < 3; r++) begin
      step();
      chk("t3_read_req", ddr3_avl_read_req, 1);
      chk("t3_p0_grant", p0_ready, !exp_seq[r]);
      chk("t3_p1_grant", p1_ready, exp_seq[r]);
      if (r == 2) begin p0_read_req = 0; p1_read_req = 0; end
      step();
      chk("t3_idle", ddr3_avl_read_req, 0);
    end
    for (int k = 0; k < 3; k++) begin
      ddr3_avl_read_data_valid = 1; ddr3_avl_read_data = 128'hC0 + 128'(k);
      #1;
      chk("t3_ret_p0", p0_read_data_valid, !exp_seq[k]);
      chk("t3_ret_p1", p1_read_data_valid, exp_seq[k]);
      step();
    end
    ddr3_avl_read_data_valid = 0;

    // Nine p1 reads with no return data: ninth stalls on a full tag FIFO
    p1_read_req = 1; p1_addr = 26'h300; p1_size = 3'd1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t4_accept", p1_ready, 1);
      step();
    end
    step();
    chk("t4_stall_a", ddr3_avl_read_req, 0);
    step();
    chk("t4_stall_b", ddr3_avl_read_req, 0);
    ddr3_avl_read_data_valid = 1; ddr3_avl_read_data = 128'hD0;
    #1 chk("t4_free_beat", p1_read_data_valid, 1);
    step();
    ddr3_avl_read_data_valid = 0;
    chk("t4_still_idle", ddr3_avl_read_req, 0);
    step();
    chk("t4_ninth_req", ddr3_avl_read_req, 1);
    chk("t4_ninth_rdy", p1_ready, 1);
    p1_read_req = 0;
    step();
    for (int k = 0; k < 8; k++) begin
      ddr3_avl_read_data_valid = 1;
      #1;
      chk("t4_drain_p1", p1_read_data_valid, 1);
      chk("t4_drain_p0", p0_read_data_valid, 0);
      step();
    end
    ddr3_avl_read_data_valid = 0;
    chk("t4_no_orphan", err_orphan, 0);

    // Size 0 latches as 1; an extra beat then becomes an orphan
    p0_read_req = 1; p0_addr = 26'h40; p0_size = 3'd0;
    step();
    chk("t5_size0", ddr3_avl_size, 1);
    p0_read_req = 0;
    step();
    ddr3_avl_read_data_valid = 1;
    #1 chk("t5_beat", p0_read_data_valid, 1);
    step();
    #1;
    chk("t5_orph_p0", p0_read_data_valid, 0);
    chk("t5_orph_p1", p1_read_data_valid, 0);
    chk("t5_err_pre", err_orphan, 0);
    step();
    ddr3_avl_read_data_valid = 0;
    chk("t5_err_set", err_orphan, 1);
    step();
    chk("t5_err_sticky", err_orphan, 1);

    // Reset in the middle of a write burst
    p0_write_req = 1; p0_addr = 26'h50; p0_size = 3'd5; p0_wr_data = 128'hE5; ddr3_avl_ready = 0;
    step();
    chk("t6_wr_active", ddr3_avl_write_req, 1);
    chk("t6_wd", ddr3_avl_wr_data, 128'hE5);
    ddr3_avl_ready = 1; ddr3_avl_read_data = 128'hF00D;
    reset_n = 0;
    #1;
    chk("t6_rst_wr", ddr3_avl_write_req, 0);
    chk("t6_rst_bb", ddr3_avl_burstbegin, 0);
    chk("t6_rst_wd", ddr3_avl_wr_data, 0);
    chk("t6_rst_addr", ddr3_avl_addr, 0);
    chk("t6_rst_size", ddr3_avl_size, 0);
    chk("t6_rst_rdy", p0_ready, 0);
    chk("t6_rst_rdata", p0_read_data, 0);
    chk("t6_rst_err", err_orphan, 0);
    p0_write_req = 0;
    @(negedge clk) reset_n = 1;
    step();
    chk("t6_post_wr", ddr3_avl_write_req, 0);
    chk("t6_post_rdata", p1_read_data, 128'hF00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
